decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage of the RV32I pipeline. Accepts one fetched instruction per cycle.
//  Drives rs1/rs2 addresses to register_file and captures its read data.
//  Generates the immediate and writes an ID/EX pipeline register read by EX.
//  Bypasses the same-edge writeback and interlocks on load-use hazards.
// PARAMETERS
//  XLEN       32  datapath width; only 32 is supported
//  BYPASS_EN  1   1 = forward wb_rd_data at capture and during hold; 0 = none (test only)
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  if_valid        in   1     fetch presents an instruction
//  if_ready        out  1     decode accepts this cycle
//  if_instr        in   32    instruction word
//  if_pc           in   32    instruction PC
//  rs1_addr        out  5     to register_file = if_instr[19:15] (combinational)
//  rs2_addr        out  5     to register_file = if_instr[24:20] (combinational)
//  rs1_data        in   32    from register_file
//  rs2_data        in   32    from register_file
//  wb_reg_write    in   1     writeback enable (same net as register_file.reg_write)
//  wb_rd_addr      in   5     writeback destination
//  wb_rd_data      in   32    writeback data
//  ex_load_pending in   1     EX holds a load whose result is not yet written back
//  ex_load_rd      in   5     destination of that load
//  flush           in   1     kill the held and the incoming instruction (branch/jump)
//  ex_valid        out  1     ID/EX register holds a valid instruction
//  ex_ready        in   1     EX consumes the held instruction this cycle
//  ex_pc, ex_rs1_val, ex_rs2_val, ex_imm   out 32 each   registered operands
//  ex_rd_addr      out  5     destination; forced to 0 when the instruction has no rd
//  ex_opcode/ex_funct3/ex_funct7b5  out 7/3/1  registered decode fields
//  ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal  out 1 each
// BEHAVIOUR
//  Reset: every ex_* output = 0, including ex_valid. Reset acts asynchronously
//   mid-operation and discards the held instruction.
//  Source use: rs1 used except LUI/AUIPC/JAL. rs2 used only by OP/STORE/BRANCH.
//  hazard = ex_load_pending & ex_load_rd!=0 & (used rs1 or used rs2 equals ex_load_rd).
//  if_ready = (!ex_valid | ex_ready) & !hazard & !flush.
//  Accept (if_valid & if_ready): the ID/EX register loads at the next edge.
//   Latency is 1 cycle, from if_valid&if_ready to ex_valid.
//  Else if ex_ready | !ex_valid: ex_valid <= 0 (bubble).
//   Else the register holds its value, and if_valid/if_instr must stay stable.
//  flush has top priority: ex_valid <= 0 at the next edge, and nothing is accepted that cycle.
//  Capture bypass: when wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==rsN_addr,
//   ex_rsN_val <= wb_rd_data; otherwise ex_rsN_val <= rs_data.
//   Unused sources are captured as 0. A source of x0 is always 0.
//  Hold snoop: while ex_valid & !ex_ready, a writeback matching a held used source
//   address that is not x0 updates that ex_rsN_val. The stage keeps the held source addresses internally.
//  Immediate, sign-extended: I (OP-IMM, LOAD, JALR), S, B (bit0=0), U (low 12=0), J (bit0=0).
//   ex_imm = 0 for OP.
//  ex_reg_write = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd!=0.
//  ex_illegal = 1 for an opcode outside RV32I base (incl. FENCE/SYSTEM excluded) or instr[1:0]!=2'b11.
//   An illegal instruction still advances, with ex_reg_write, ex_mem_read and ex_mem_write all 0.
// TESTING
//  1) Reset, then if_instr=addi x1,x0,5 with if_valid=1 and ex_ready=1
//     -> next cycle: ex_valid=1, ex_imm=5, ex_rd_addr=1, ex_reg_write=1.
//  2) RF x2=7; wb writes x2=9 on the capture edge; instr add x3,x2,x2
//     -> ex_rs1_val=ex_rs2_val=9.
//  3) ex_load_pending=1, ex_load_rd=4; instr sub x5,x4,x1
//     -> if_ready=0 until pending drops, then accepted the next cycle.
//  4) Instruction held with ex_ready=0; wb writes x6=0xDEAD and x6 is held rs2
//     -> ex_rs2_val=0xDEAD. A write to x0 changes nothing.
//  5) flush pulses while ex_valid=1 and if_valid=1
//     -> ex_valid=0 next cycle and the incoming instruction is dropped.
//  6) beq with offset -8 -> ex_imm=0xFFFFFFF8.
//     Word 0x00000000 -> ex_illegal=1 with ex_reg_write=0.
//     rst_n low mid-hold -> ex_valid=0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the RV32I pipeline.
//   Decodes one fetched instruction per cycle and drives rs1/rs2 addresses to
//   the register file. It captures operands, with a same-edge writeback
//   bypass, generates the sign-extended immediate and loads the ID/EX register.
//   It stalls fetch on a load-use hazard or when EX does not consume.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   if_valid, if_ready, if_instr, if_pc   fetch handshake and instruction
//   rs1_addr, rs2_addr, rs1_data, rs2_data   register file read port
//   wb_reg_write, wb_rd_addr, wb_rd_data     writeback (bypass / snoop source)
//   ex_load_pending, ex_load_rd     outstanding load in EX (interlock)
//   flush                           kill held and incoming instruction
//   ex_valid, ex_ready              ID/EX handshake
//   ex_*                            registered operands and decode fields
module decode_stage #(
  parameter int XLEN      = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            ex_load_pending,
  input  logic [4:0]      ex_load_rd,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd_addr,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic            use1, use2, legal, has_rd, is_load, is_store;
  logic [XLEN-1:0] imm;
  logic            hazard, accept;
  logic [XLEN-1:0] cap1, cap2;
  logic [4:0]      held_rs1, held_rs2;
  logic            snoop1, snoop2;

  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  // Opcode field includes instr[1:0], so any non-11 encoding falls to default.
  always_comb begin
    use1     = 1'b1;
    use2     = 1'b0;
    legal    = 1'b1;
    has_rd   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    imm      = '0;
    case (if_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        use1   = 1'b0;
        has_rd = 1'b1;
        imm    = {if_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        use1   = 1'b0;
        has_rd = 1'b1;
        imm    = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_OPIMM: begin
        has_rd = 1'b1;
        imm    = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OPC_LOAD: begin
        has_rd  = 1'b1;
        is_load = 1'b1;
        imm     = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OPC_STORE: begin
        use2     = 1'b1;
        is_store = 1'b1;
        imm      = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      OPC_BRANCH: begin
        use2 = 1'b1;
        imm  = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25],
                if_instr[11:8], 1'b0};
      end
      OPC_OP: begin
        use2   = 1'b1;
        has_rd = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign hazard = ex_load_pending && (ex_load_rd != 5'd0) &&
                  ((use1 && rs1_addr == ex_load_rd) ||
                   (use2 && rs2_addr == ex_load_rd));
  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;

  always_comb begin
    cap1 = '0;
    cap2 = '0;
    if (use1 && rs1_addr != 5'd0)
      cap1 = (BYPASS_EN && wb_reg_write && wb_rd_addr == rs1_addr) ? wb_rd_data : rs1_data;
    if (use2 && rs2_addr != 5'd0)
      cap2 = (BYPASS_EN && wb_reg_write && wb_rd_addr == rs2_addr) ? wb_rd_data : rs2_data;
  end

  // Held addresses are stored as 0 when unused, so a nonzero writeback can never match them.
  assign snoop1 = BYPASS_EN && wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == held_rs1;
  assign snoop2 = BYPASS_EN && wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == held_rs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd_addr   <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
      held_rs1     <= '0;
      held_rs2     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_rs1_val   <= cap1;
      ex_rs2_val   <= cap2;
      ex_imm       <= imm;
      ex_rd_addr   <= (legal && has_rd) ? if_instr[11:7] : 5'd0;
      ex_opcode    <= if_instr[6:0];
      ex_funct3    <= if_instr[14:12];
      ex_funct7b5  <= if_instr[30];
      ex_reg_write <= legal && has_rd && (if_instr[11:7] != 5'd0);
      ex_mem_read  <= is_load;
      ex_mem_write <= is_store;
      ex_illegal   <= !legal;
      held_rs1     <= use1 ? rs1_addr : 5'd0;
      held_rs2     <= use2 ? rs2_addr : 5'd0;
    end else if (ex_ready || !ex_valid) begin
      ex_valid <= 1'b0;
    end else begin
      if (snoop1) ex_rs1_val <= wb_rd_data;
      if (snoop2) ex_rs2_val <= wb_rd_data;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios followed by randomized traffic, checked
// against an instruction-level reference model (architectural register file
// plus decoded ID/EX contents).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        ex_load_pending;
  logic [4:0]  ex_load_rd;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd_addr;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .ex_load_pending(ex_load_pending), .ex_load_rd(ex_load_rd), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd_addr(ex_rd_addr), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
  );

  // Architectural register file; x0 reads return garbage to prove the stage zeroes x0.
  logic [31:0] rf [32];
  assign rs1_data = (if_instr[19:15] == 5'd0) ? 32'hBAD0_0001 : rf[if_instr[19:15]];
  assign rs2_data = (if_instr[24:20] == 5'd0) ? 32'hBAD0_0002 : rf[if_instr[24:20]];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rd, s1, s2;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, rw, mr, mw, ill;
  } ex_t;

  ex_t  m;
  logic accepted;

  function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned n);
    return v[n-1] ? v - (32'd1 << n) : v;
  endfunction

  // Decode from the ISA tables; s1/s2 hold the used source register or 0.
  function automatic ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    ex_t  e     = '0;
    logic legal = 1'b1;
    logic rd_ok = 1'b0;
    logic u1    = 1'b1;
    logic u2    = 1'b0;
    case (ins[6:0])
      7'h37, 7'h17: begin e.imm = ins & 32'hFFFF_F000; u1 = 1'b0; rd_ok = 1'b1; end
      7'h6F: begin
        e.imm = sext({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        u1 = 1'b0; rd_ok = 1'b1;
      end
      7'h67, 7'h13: begin e.imm = sext({20'd0, ins[31:20]}, 12); rd_ok = 1'b1; end
      7'h03: begin e.imm = sext({20'd0, ins[31:20]}, 12); rd_ok = 1'b1; e.mr = 1'b1; end
      7'h23: begin e.imm = sext({20'd0, ins[31:25], ins[11:7]}, 12); u2 = 1'b1; e.mw = 1'b1; end
      7'h63: begin
        e.imm = sext({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        u2 = 1'b1;
      end
      7'h33: begin u2 = 1'b1; rd_ok = 1'b1; end
      default: legal = 1'b0;
    endcase
    e.valid = 1'b1;
    e.pc    = pc;
    e.rd    = rd_ok ? ins[11:7] : 5'd0;
    e.rw    = rd_ok && ins[11:7] != 5'd0;
    e.s1    = u1 ? ins[19:15] : 5'd0;
    e.s2    = u2 ? ins[24:20] : 5'd0;
    e.op    = ins[6:0];
    e.f3    = ins[14:12];
    e.f7    = ins[30];
    e.ill   = !legal;
    return e;
  endfunction

  task automatic check_outputs(input logic all_fields);
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
    if (all_fields || m.valid) begin
      check("ex_pc", ex_pc, m.pc);
      check("ex_rs1_val", ex_rs1_val, m.rs1v);
      check("ex_rs2_val", ex_rs2_val, m.rs2v);
      check("ex_imm", ex_imm, m.imm);
      check("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, m.rd});
      check("ex_opcode", {25'd0, ex_opcode}, {25'd0, m.op});
      check("ex_funct3", {29'd0, ex_funct3}, {29'd0, m.f3});
      check("ex_ctrl", {27'd0, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal},
                       {27'd0, m.f7, m.rw, m.mr, m.mw, m.ill});
    end
  endtask

  // Called just after inputs are driven on the falling edge; returns #1 after the rising edge.
  task automatic cycle();
    ex_t         nxt;
    ex_t         inc;
    logic [31:0] rfn [32];
    logic        exp_ready, haz;
    #1;
    inc = ref_decode(if_instr, if_pc);
    haz = ex_load_pending && ex_load_rd != 5'd0 &&
          (inc.s1 == ex_load_rd || inc.s2 == ex_load_rd);
    exp_ready = (!m.valid || ex_ready) && !haz && !flush;
    check("if_ready", {31'd0, if_ready}, {31'd0, exp_ready});
    check("rs1_addr", {27'd0, rs1_addr}, {27'd0, if_instr[19:15]});
    check("rs2_addr", {27'd0, rs2_addr}, {27'd0, if_instr[24:20]});
    rfn = rf;
    if (wb_reg_write && wb_rd_addr != 5'd0) rfn[wb_rd_addr] = wb_rd_data;
    nxt = m;
    accepted = 1'b0;
    if (flush) nxt.valid = 1'b0;
    else if (if_valid && exp_ready) begin
      nxt      = inc;
      nxt.rs1v = rfn[inc.s1];
      nxt.rs2v = rfn[inc.s2];
      accepted = 1'b1;
    end else if (!m.valid || ex_ready) nxt.valid = 1'b0;
    else begin
      // A held operand always tracks the current architectural register value.
      nxt.rs1v = rfn[m.s1];
      nxt.rs2v = rfn[m.s2];
    end
    @(posedge clk);
    #1;
    rf = rfn;
    m  = nxt;
    check_outputs(1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
    ins        = $urandom;
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[6:0]   = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 19) == 0) ins[1:0] = 2'($urandom_range(0, 2));
    return ins;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    wb_reg_write = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;
    ex_load_pending = 1'b0; ex_load_rd = '0; flush = 1'b0; ex_ready = 1'b1;
    m = '0; accepted = 1'b0;
    @(negedge clk); @(negedge clk);
    check_outputs(1'b1);
    rst_n = 1'b1;

    // addi x1,x0,5
    @(negedge clk);
    if_valid = 1'b1; if_instr = 32'h0050_0093; if_pc = 32'h100;
    cycle();
    check("t1_imm", ex_imm, 32'd5);
    check("t1_rd", {27'd0, ex_rd_addr}, 32'd1);
    check("t1_rw", {31'd0, ex_reg_write}, 32'd1);

    // add x3,x2,x2 with x2 written 7 -> 9 on the capture edge
    @(negedge clk);
    rf[2] = 32'd7;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd2; wb_rd_data = 32'd9;
    if_instr = 32'h0021_01B3; if_pc = 32'h104;
    cycle();
    check("t2_rs1", ex_rs1_val, 32'd9);
    check("t2_rs2", ex_rs2_val, 32'd9);
    wb_reg_write = 1'b0;

    // sub x5,x4,x1 behind a pending load to x4
    @(negedge clk);
    ex_load_pending = 1'b1; ex_load_rd = 5'd4;
    if_instr = 32'h4012_02B3; if_pc = 32'h108;
    cycle();
    check("t3_stall", {31'd0, if_ready}, 32'd0);
    @(negedge clk);
    cycle();
    check("t3_bubble", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    ex_load_pending = 1'b0;
    cycle();
    check("t3_accept", {31'd0, ex_valid}, 32'd1);
    check("t3_rd", {27'd0, ex_rd_addr}, 32'd5);

    // add x7,x1,x6 held; x6 written while held, then a write to x0
    @(negedge clk);
    if_instr = 32'h0060_83B3; if_pc = 32'h10C;
    cycle();
    @(negedge clk);
    if_valid = 1'b0; ex_ready = 1'b0;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd6; wb_rd_data = 32'h0000_DEAD;
    cycle();
    check("t4_snoop", ex_rs2_val, 32'h0000_DEAD);
    @(negedge clk);
    wb_rd_addr = 5'd0; wb_rd_data = 32'h1234_5678;
    cycle();
    check("t4_x0", ex_rs2_val, 32'h0000_DEAD);
    wb_reg_write = 1'b0;

    // flush while holding and while a new instruction is offered
    @(negedge clk);
    flush = 1'b1; if_valid = 1'b1; if_instr = 32'h0050_0093; if_pc = 32'h110;
    cycle();
    check("t5_flush", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0; if_valid = 1'b0;
    cycle();
    check("t5_drop", {31'd0, ex_valid}, 32'd0);

    // beq x0,x0,-8 then the all-zero word
    @(negedge clk);
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'hFE00_0CE3; if_pc = 32'h114;
    cycle();
    check("t6_bimm", ex_imm, 32'hFFFF_FFF8);
    @(negedge clk);
    if_instr = 32'h0000_0000; if_pc = 32'h118;
    cycle();
    check("t6_ill", {31'd0, ex_illegal}, 32'd1);
    check("t6_ill_rw", {31'd0, ex_reg_write}, 32'd0);

    // reset while the illegal instruction is held
    @(negedge clk);
    if_valid = 1'b0; ex_ready = 1'b0;
    cycle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m = '0;
    check("t6_async_rst", {31'd0, ex_valid}, 32'd0);
    check_outputs(1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic; an offered instruction stays put until accepted or flushed
    accepted = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!(if_valid && !accepted && !flush)) begin
        if_valid = ($urandom_range(0, 9) < 8);
        if_instr = rand_instr();
        if_pc    = $urandom & 32'hFFFF_FFFC;
      end
      flush           = ($urandom_range(0, 19) == 0);
      ex_ready        = ($urandom_range(0, 9) < 6);
      wb_reg_write    = $urandom_range(0, 1) == 1;
      wb_rd_addr      = 5'($urandom_range(0, 7));
      wb_rd_data      = $urandom;
      ex_load_pending = ($urandom_range(0, 9) < 3);
      ex_load_rd      = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
